mem_port_arbiter: RTL

- Shares the processor's single unified memory port between the instruction-fetch path and the load/store path.
- Keeps one transaction in flight at a time.
- Captures the winning request, drives the memory handshake and returns read data to the owner with a one-cycle done pulse.
- Adds a starvation guard so fetch always makes progress.
- Sits between the PC/fetch logic, the LSU and the external memory.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_streak_counter.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned AW_DEFAULT            = 32;
    localparam int unsigned DW_DEFAULT            = 32;
    localparam int unsigned LS_STREAK_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory handshake signals around the arbiter.
// master: the arbiter itself; slave: the requesters and memory around it.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
);

    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_done;
    logic [DW-1:0]   if_rdata;

    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_be;
    logic            ls_done;
    logic [DW-1:0]   ls_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    logic            busy;

    modport master (
        input  if_req, if_addr,
        output if_done, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_done, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_done, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_streak_counter.sv
// Grant decision between fetch and load/store, with a saturating count of
// consecutive load/store wins taken while fetch was waiting.
module arb_streak_counter #(
    parameter int unsigned LS_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic ls_req_i,
    input  logic eval_i,
    output logic grant_ls_o
);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       at_max;

    assign at_max     = (streak_q == 4'(LS_STREAK_MAX));
    assign grant_ls_o = ls_req_i && (!if_req_i || !at_max);

    // NOTE: streak_d gets its hold value first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        streak_d = streak_q;
        if (eval_i && (if_req_i || ls_req_i)) begin
            if (grant_ls_o && if_req_i) begin
                streak_d = at_max ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a
// time, returning read data to the owner with a single-cycle done pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW            = AW_DEFAULT,
    parameter int unsigned DW            = DW_DEFAULT,
    parameter int unsigned LS_STREAK_MAX = LS_STREAK_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    state_e          state_q;
    owner_e          owner_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [DW/8-1:0] mem_be_q;
    logic            if_done_q;
    logic            ls_done_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   ls_rdata_q;

    logic            eval;
    logic            grant_ls;
    logic            complete;

    assign eval = (state_q == ST_IDLE);

    arb_streak_counter #(
        .LS_STREAK_MAX(LS_STREAK_MAX)
    ) u_streak (
        .clk       (clk),
        .reset     (reset),
        .if_req_i  (bus.if_req),
        .ls_req_i  (bus.ls_req),
        .eval_i    (eval),
        .grant_ls_o(grant_ls)
    );

    // Completion can come straight out of ISSUE when memory answers in the accept cycle.
    assign complete = ((state_q == ST_ISSUE) && bus.mem_ready && bus.mem_rvalid) ||
                      ((state_q == ST_WAIT)  && bus.mem_rvalid);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.if_req || bus.ls_req) begin
                        state_q   <= ST_ISSUE;
                        mem_req_q <= 1'b1;
                        if (grant_ls) begin
                            owner_q     <= OWN_LS;
                            mem_we_q    <= bus.ls_we;
                            mem_addr_q  <= bus.ls_addr;
                            mem_wdata_q <= bus.ls_wdata;
                            mem_be_q    <= bus.ls_be;
                        end else begin
                            owner_q     <= OWN_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= '1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= bus.mem_rvalid ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase

            if (complete) begin
                if (owner_q == OWN_LS) begin
                    ls_done_q <= 1'b1;
                    if (!mem_we_q) begin
                        ls_rdata_q <= bus.mem_rdata;
                    end
                end else begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
